// File: rtl/iteration_pixel_unpacker_if.sv
// iteration_pixel_unpacker_if: read-FIFO and HDMI pixel signals of the unpacker
interface iteration_pixel_unpacker_if;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_en;
  logic        stream_data;
  logic        end_line;
  logic [23:0] data_out;
  logic        data_out_valid;
  logic        underflow;
  logic        align_err;
  modport master (
    output rd_data, rd_empty, stream_data, end_line,
    input  rd_en, data_out, data_out_valid, underflow, align_err
  );
  modport slave (
    input  rd_data, rd_empty, stream_data, end_line,
    output rd_en, data_out, data_out_valid, underflow, align_err
  );
endinterface

// File: rtl/iteration_pixel_unpacker.sv
// iteration_pixel_unpacker: unpacks four 8-bit iteration counts per FIFO word into RGB pixels
module iteration_pixel_unpacker #(
  parameter int max_iterations = 255,
  parameter int ITER_WIDTH     = 8
) (
  input logic clk,
  input logic reset,
  iteration_pixel_unpacker_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
  occ_t                  state_q, state_d;
  logic [31:0]           cur_q, cur_d, nxt_q, nxt_d;
  logic [1:0]            idx_q, idx_d, idx_nx;
  logic [23:0]           data_q, data_d;
  logic                  valid_q, valid_d, under_q, under_d, align_q, align_d;
  logic [ITER_WIDTH-1:0] cnt;
  logic                  cur_v, nxt_v, produce, discard, consume, cur_keep, nxt_keep, pop;
  assign bus.rd_en          = pop;
  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.underflow      = under_q;
  assign bus.align_err      = align_q;
  // slot occupancy, pop decision, byte selection and colour mapping
  always_comb begin
    cur_v    = state_q != EMPTY;
    nxt_v    = state_q == TWO;
    produce  = bus.stream_data && cur_v;
    idx_nx   = produce ? idx_q + 2'd1 : idx_q;
    discard  = bus.end_line && idx_nx != 2'd0;
    consume  = (produce && idx_q == 2'd3) || discard;
    cur_keep = cur_v && (!consume || nxt_v);
    nxt_keep = nxt_v && !consume;
    pop      = !reset && !bus.rd_empty && !(cur_keep && nxt_keep);
    cur_d    = (pop && !cur_keep) ? bus.rd_data : consume ? nxt_q : cur_q;
    nxt_d    = (pop && cur_keep) ? bus.rd_data : nxt_q;
    state_d  = (cur_keep || pop) ? (((pop && cur_keep) || nxt_keep) ? TWO : ONE) : EMPTY;
    idx_d    = consume ? 2'd0 : idx_nx;
    cnt      = cur_q[{idx_q, 3'b000} +: ITER_WIDTH];
    data_d   = !bus.stream_data ? data_q :
               (produce && cnt != ITER_WIDTH'(max_iterations)) ? {cnt, cnt[ITER_WIDTH-2:0], 1'b0, ~cnt} :
               24'h000000;
    valid_d  = bus.stream_data;
    under_d  = under_q | (bus.stream_data && !cur_v);
    align_d  = align_q | discard;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      cur_q   <= '0;
      nxt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      under_q <= under_d;
      align_q <= align_d;
    end
  end
endmodule

// File: doc/iteration_pixel_unpacker.md
Name: iteration_pixel_unpacker

Overview:
- Sits between the DDR2 port-1 read FIFO (64-deep, first-word-fall-through) and the HDMI pixel interface, in the colour clock domain.
- Pops 32-bit words, each holding four packed 8-bit iteration counts, and unpacks them one pixel per HDMI request.
- Maps each count to 24-bit RGB and presents it with a valid strobe.
- Prefetches one word so pixel streaming never stalls on the FIFO pop.

Parameters:
max_iterations, 255, iteration count meaning "inside set"; mapped to black.
ITER_WIDTH, 8, bits per packed count; fixed 8, four counts per 32-bit word.

Ports:
clk  input  1  colour clock; all logic on rising edge
reset  input  1  synchronous, active-high
rd_data  input  32  port-1 read FIFO head word; valid whenever rd_empty=0
rd_empty  input  1  port-1 read FIFO empty
rd_en  output  1  pop port-1 read FIFO
stream_data  input  1  HDMI requests one pixel this cycle
end_line  input  1  one-cycle pulse at end of active line
data_out  output  24  {red, green, blue} of current pixel
data_out_valid  output  1  data_out holds a newly produced pixel
underflow  output  1  sticky: pixel requested with no word held
align_err  output  1  sticky: end_line arrived mid-word

Behaviour:
- Reset values: rd_en=0, data_out=24'h000000, data_out_valid=0, underflow=0, align_err=0, pixel index=0, both word slots empty.
- Storage:
  - cur slot (word being unpacked) plus nxt slot (prefetched word), each with a valid bit.
  - Occupancy states: EMPTY (neither valid), ONE (cur only), TWO (cur and nxt).
  - nxt is never valid without cur.
- Pop rule: rd_en = !rd_empty && !(cur will remain valid and nxt is valid after this cycle's consumption).
  - Combinational, same cycle as rd_empty low.
  - rd_data is captured on the same edge rd_en is high.
  - Captured word goes to cur if cur is free after this cycle; otherwise it goes to nxt.
  - rd_en is never high while rd_empty=1.
  - rd_en is never high during reset.
- Unpack order: byte 0 (rd_data[7:0]) first, byte 3 (rd_data[31:24]) last. The 2-bit index selects the byte.
- On stream_data=1 with cur valid:
  - Selected count is mapped and registered into data_out.
  - data_out_valid=1 on the next cycle (latency 1).
  - Index increments.
  - At index 3, the word is consumed: index wraps to 0, nxt promotes to cur (or cur becomes invalid), and a word popped the same cycle fills the freed slot.
- On stream_data=1 with cur invalid: data_out=24'h000000, data_out_valid=1 next cycle, underflow set. Index is unchanged.
- On stream_data=0: data_out_valid=0 next cycle. data_out holds its last value.
- Colour map, count c (8-bit):
  - c == max_iterations: black, {8'h00, 8'h00, 8'h00}.
  - Otherwise: red=c, green={c[6:0],1'b0} (mod 256), blue=8'hFF-c.
- end_line:
  - With index=0: no effect on the slots.
  - With index!=0: remainder of cur is discarded (treated as consumed), index=0, align_err set.
  - end_line together with stream_data: the pixel is produced first; the check uses the index after that pixel's increment. A pixel at index 3 therefore completes cleanly with no error.
- Simultaneous consume and pop in state TWO: nxt promotes to cur and the new word loads nxt in one edge, with no bubble.
- Sticky flags clear only on reset.
- Reset mid-line: all slots are invalidated and the words they held are lost. Upstream re-fetches on reset.

Test Plan:
- Reset, then rd_empty=1 for 10 cycles -> rd_en stays 0, all outputs 0, no flags set.
- FIFO holds 32'h03020100 and 32'h07060504, stream_data held high 8 cycles after fill -> data_out sequence is {00,00,FF}, {01,02,FE}, {02,04,FD}, {03,06,FC}, {04,08,FB}, ..., {07,0E,F8}, each 1 cycle after request, data_out_valid continuous.
- Word 32'hFF7F80FE streamed -> 254={FE,FC,01}, 128={80,00,7F}, 127={7F,FE,80}, 255=24'h000000.
- FIFO continuously non-empty, stream_data high 1280 cycles -> exactly 320 pops, no gap in data_out_valid, rd_en never high with both slots full and no consumption.
- stream_data high with rd_empty=1 since reset -> data_out=0, data_out_valid=1, underflow=1 and stays 1 after data resumes.
- Two pixels of word consumed, then end_line -> align_err=1, next pixel is byte 0 of the following word; end_line coincident with 4th pixel -> align_err stays 0.
